// File: rtl/datamem_dump_ctrl_pkg.sv
// Shared types and constants for the data-memory dump controller.
package datamem_dump_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF     = 10;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/datamem_dump_ctrl_serializer.sv
// Holds one fetched memory word and presents its bytes MSB-first on a registered byte output.
module dump_word_serializer
    import datamem_dump_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              advance_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              last_c_o
);

    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BYTE_W-1:0] byte_q;

    // Index 0 selects the most-significant byte.
    function automatic logic [BYTE_W-1:0] sel_byte(input logic [DATA_W-1:0] w,
                                                   input logic [IDX_W-1:0]  i);
        logic [BYTE_W-1:0] b;
        b = w[DATA_W-1 -: BYTE_W];
        case (i)
            2'd0:    b = w[DATA_W-1              -: BYTE_W];
            2'd1:    b = w[DATA_W-1-BYTE_W       -: BYTE_W];
            2'd2:    b = w[DATA_W-1-(2*BYTE_W)   -: BYTE_W];
            2'd3:    b = w[DATA_W-1-(3*BYTE_W)   -: BYTE_W];
            default: b = w[DATA_W-1              -: BYTE_W];
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            byte_q <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= '0;
            byte_q <= sel_byte(word_i, IDX_W'(0));
        end else if (advance_i) begin
            idx_q  <= idx_q + IDX_W'(1);
            byte_q <= sel_byte(word_q, idx_q + IDX_W'(1));
        end
    end

    assign byte_o   = byte_q;
    assign last_c_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/datamem_dump_ctrl.sv
// Walks an inclusive, wrapping word-address range of data memory and streams each word to a UART byte by byte.
module datamem_dump_ctrl
    import datamem_dump_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] con_addr,
    output logic              con_rd,
    input  logic [DATA_W-1:0] con_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_q;
    logic              con_rd_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;

    logic              xfer_c;
    logic              last_byte_c;
    logic              ser_load_c;
    logic              ser_adv_c;

    assign xfer_c     = tx_valid_q & tx_ready;
    assign ser_load_c = (state_q == ST_WAIT);
    assign ser_adv_c  = (state_q == ST_SEND) & xfer_c & ~last_byte_c;

    dump_word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk       (CLK),
        .rst       (rst),
        .load_i    (ser_load_c),
        .word_i    (con_data),
        .advance_i (ser_adv_c),
        .byte_o    (tx_data),
        .last_c_o  (last_byte_c)
    );

    // The address counter doubles as the read address, so it holds outside READ.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            con_rd_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            con_rd_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q   <= first_addr;
                        last_q   <= last_addr;
                        con_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer_c && last_byte_c) begin
                        tx_valid_q <= 1'b0;
                        if (addr_q == last_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            addr_q   <= addr_q + ADDR_W'(1);
                            con_rd_q <= 1'b1;
                            state_q  <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign con_addr = addr_q;
    assign con_rd   = con_rd_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_datamem_dump_ctrl.sv
// Self-checking bench for datamem_dump_ctrl: memory model, UART sink and a range-based reference model.
module tb_datamem_dump_ctrl;

    logic        CLK;
    logic        rst;
    logic        start;
    logic [9:0]  first_addr;
    logic [9:0]  last_addr;
    logic [9:0]  con_addr;
    logic        con_rd;
    logic [31:0] con_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    logic [31:0] mem [0:1023];

    // Monitor records
    int          cyc;
    bit          prev_valid;
    logic [7:0]  got_q[$];
    int          hs_cyc[$];
    int          rise_cyc[$];
    logic [9:0]  rd_q[$];
    int          done_cnt;
    int          start_cyc;
    bit          rand_ready;

    datamem_dump_ctrl dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .con_addr   (con_addr),
        .con_rd     (con_rd),
        .con_data   (con_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous-read data memory
    always @(posedge CLK) begin
        if (con_rd) con_data <= mem[con_addr];
    end

    // Random transmitter backpressure
    initial begin
        forever begin
            @(negedge CLK);
            if (rand_ready) tx_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Observe the interface in the middle of each cycle
    initial begin
        cyc = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            cyc++;
            if (rst === 1'b0) begin
                if (start === 1'b1 && busy === 1'b0) start_cyc = cyc;
                if (tx_valid === 1'b1 && !prev_valid) rise_cyc.push_back(cyc);
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    got_q.push_back(tx_data);
                    hs_cyc.push_back(cyc);
                end
                if (con_rd === 1'b1) rd_q.push_back(con_addr);
                if (done === 1'b1) done_cnt++;
            end
            prev_valid = (tx_valid === 1'b1);
        end
    end

    task automatic clear_mon();
        got_q.delete();
        hs_cyc.delete();
        rise_cyc.delete();
        rd_q.delete();
        done_cnt  = 0;
        start_cyc = -100;
    endtask

    task automatic start_dump(input logic [9:0] f, input logic [9:0] l);
        clear_mon();
        @(negedge CLK);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(negedge CLK);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge CLK);
        #2;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b1;
        first_addr = 10'h055;
        last_addr  = 10'h056;
        repeat (3) @(negedge CLK);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        checks++; if (con_rd !== 1'b0)   begin errors++; $display("FAIL reset_con_rd got=%b want=0", con_rd); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (con_addr !== 10'h0) begin errors++; $display("FAIL reset_con_addr got=%h want=000", con_addr); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        @(negedge CLK);
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        checks++; if (busy !== 1'b0 || con_rd !== 1'b0) begin
            errors++; $display("FAIL reset_start_ignored busy=%b con_rd=%b want 0/0", busy, con_rd);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] eb [4];
        bit ok;
        eb[0] = 8'hAD; eb[1] = 8'hE1; eb[2] = 8'hB0; eb[3] = 8'h56;
        mem[0] = 32'hADE1B056;
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        start_dump(10'h000, 10'h000);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout done_cnt=%0d want>=1", done_cnt); end
        checks++;
        if (got_q.size() != 4) begin
            errors++; $display("FAIL single_count got=%0d want=4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== eb[i]) begin errors++; $display("FAIL single_byte%0d got=%h want=%h", i, got_q[i], eb[i]); end
            end
            checks++;
            if (hs_cyc[3] - hs_cyc[0] != 3) begin
                errors++; $display("FAIL single_consecutive span=%0d want=3", hs_cyc[3] - hs_cyc[0]);
            end
        end
        checks++;
        if (rise_cyc.size() < 1 || rise_cyc[0] - start_cyc != 3) begin
            errors++; $display("FAIL single_latency got=%0d want=3", (rise_cyc.size() > 0) ? rise_cyc[0] - start_cyc : -1);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done got=%0d want=1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b want=0", busy); end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 10'h000) begin
            errors++; $display("FAIL single_reads count=%0d want=1 at 000", rd_q.size());
        end
    endtask

    // One dump of an inclusive, wrapping range against a plain address/byte model
    task automatic test_range(input string nm, input logic [9:0] f, input logic [9:0] l, input bit rnd);
        int n;
        logic [9:0] a;
        logic [7:0] eb[$];
        logic [9:0] ea[$];
        bit ok;
        n = ((int'(l) - int'(f) + 1024) % 1024) + 1;
        for (int i = 0; i < n; i++) begin
            a = 10'((int'(f) + i) % 1024);
            ea.push_back(a);
            for (int b = 0; b < 4; b++) eb.push_back(8'(mem[a] >> (8 * (3 - b))));
        end
        rand_ready = rnd;
        if (!rnd) tx_ready = 1'b1;
        start_dump(f, l);
        wait_done(n * 60 + 50, ok);
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout done_cnt=%0d want>=1", nm, done_cnt); end
        checks++;
        if (rd_q.size() != n) begin
            errors++; $display("FAIL %s_read_count got=%0d want=%0d", nm, rd_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rd_q[i] !== ea[i]) begin errors++; $display("FAIL %s_addr%0d got=%h want=%h", nm, i, rd_q[i], ea[i]); end
            end
        end
        checks++;
        if (got_q.size() != eb.size()) begin
            errors++; $display("FAIL %s_byte_count got=%0d want=%0d", nm, got_q.size(), eb.size());
        end else begin
            for (int i = 0; i < eb.size(); i++) begin
                checks++;
                if (got_q[i] !== eb[i]) begin errors++; $display("FAIL %s_byte%0d got=%h want=%h", nm, i, got_q[i], eb[i]); end
            end
        end
        checks++;
        if (rise_cyc.size() < 1 || rise_cyc[0] - start_cyc != 3) begin
            errors++; $display("FAIL %s_latency got=%0d want=3", nm, (rise_cyc.size() > 0) ? rise_cyc[0] - start_cyc : -1);
        end
        for (int w = 1; w < n; w++) begin
            checks++;
            if (rise_cyc.size() <= w || hs_cyc.size() < 4 * w) begin
                errors++; $display("FAIL %s_gap%0d missing word start", nm, w);
            end else if (rise_cyc[w] - hs_cyc[4 * w - 1] != 3) begin
                errors++; $display("FAIL %s_gap%0d got=%0d idle cycles want=2", nm, w, rise_cyc[w] - hs_cyc[4 * w - 1] - 1);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done got=%0d want=1", nm, done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got=%b want=0", nm, busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        mem[10'h020] = 32'hADE1B055;
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        start_dump(10'h020, 10'h020);
        wait_bytes(2, 50, ok);
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++; $display("FAIL bp_reach_byte2 got=%0d bytes want=2", got_q.size());
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hB0) begin
                errors++; $display("FAIL bp_hold%0d valid=%b data=%h want 1/b0", i, tx_valid, tx_data);
            end
            @(negedge CLK);
        end
        tx_ready = 1'b1;
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout done_cnt=%0d want>=1", done_cnt); end
        checks++;
        if (got_q.size() != 4 || got_q[0] !== 8'hAD || got_q[1] !== 8'hE1 || got_q[2] !== 8'hB0 || got_q[3] !== 8'h55) begin
            errors++; $display("FAIL bp_stream count=%0d want 4 bytes AD E1 B0 55", got_q.size());
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int i = 0; i < 4; i++) mem[10'h100 + i] = $urandom;
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        start_dump(10'h100, 10'h103);
        wait_bytes(1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_byte1 got=%0d bytes want=1", got_q.size()); end
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || con_rd !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL rstmid_outputs valid=%b busy=%b rd=%b data=%h want 0/0/0/00", tx_valid, busy, con_rd, tx_data);
        end
        repeat (8) @(negedge CLK);
        #1;
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_no_more_bytes got=%0d want=1", got_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt); end
        for (int i = 0; i < 2; i++) mem[10'h200 + i] = $urandom;
        test_range("rstmid_restart", 10'h200, 10'h201, 1'b0);
    endtask

    task automatic test_ignored_start();
        bit ok;
        logic [7:0] eb[$];
        mem[10'h050] = $urandom;
        mem[10'h051] = $urandom;
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 4; b++) eb.push_back(8'(mem[10'h050 + w] >> (8 * (3 - b))));
        rand_ready = 1'b1;
        start_dump(10'h050, 10'h051);
        for (int i = 0; i < 3; i++) begin
            repeat (2 + i) @(negedge CLK);
            if (busy === 1'b1) begin
                first_addr = 10'h300;
                last_addr  = 10'h30F;
                start      = 1'b1;
                @(negedge CLK);
                start      = 1'b0;
            end
        end
        wait_done(300, ok);
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        repeat (10) @(negedge CLK);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL ign_timeout done_cnt=%0d want>=1", done_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done got=%0d want=1", done_cnt); end
        checks++; if (rd_q.size() != 2) begin errors++; $display("FAIL ign_reads got=%0d want=2", rd_q.size()); end
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL ign_byte_count got=%0d want=8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== eb[i]) begin errors++; $display("FAIL ign_byte%0d got=%h want=%h", i, got_q[i], eb[i]); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b want=0", busy); end
    endtask

    task automatic test_random();
        logic [9:0] f;
        logic [9:0] l;
        int len;
        for (int t = 0; t < 6; t++) begin
            f   = 10'($urandom_range(0, 1023));
            len = $urandom_range(1, 4);
            l   = 10'((int'(f) + len - 1) % 1024);
            for (int i = 0; i < len; i++) mem[10'((int'(f) + i) % 1024)] = $urandom;
            test_range($sformatf("rand%0d", t), f, l, 1'b1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        rst        = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        con_data   = '0;
        done_cnt   = 0;
        start_cyc  = -100;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        test_reset();
        test_single_word();
        for (int i = 0; i < 3; i++) mem[10'h010 + i] = $urandom;
        test_range("multi", 10'h010, 10'h012, 1'b0);
        test_range("wrap", 10'h3FE, 10'h001, 1'b1);
        test_backpressure();
        test_reset_mid();
        test_ignored_start();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datamem_dump_ctrl.md
DATAMEM_DUMP_CTRL -- requirements
Module: datamem_dump_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, data-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data-memory word width; fixed at 4 bytes.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port first_addr  input  ADDR_W  first word address to dump.
REQ-007 SHALL have port last_addr  input  ADDR_W  last word address to dump, inclusive.
REQ-008 SHALL have port con_addr  output  ADDR_W  data-memory read address.
REQ-009 SHALL have port con_rd  output  1  data-memory read strobe.
REQ-010 SHALL have port con_data  input  DATA_W  read data, valid one cycle after con_addr/con_rd are sampled.
REQ-011 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-012 SHALL have port tx_valid  output  1  tx_data valid.
REQ-013 SHALL have port tx_ready  input  1  transmitter accepts byte.
REQ-014 SHALL have port busy  output  1  dump in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT, SEND, DONE.
REQ-017 IDLE: start=1 SHALL latch first_addr/last_addr, load address counter with first_addr, go READ; start outside IDLE SHALL be ignored.
REQ-018 READ (1 cycle): con_rd=1, con_addr=address counter; go WAIT.
REQ-019 WAIT (1 cycle): capture con_data into word register at end of cycle, byte index=0, go SEND.
REQ-020 SEND: tx_valid=1, tx_data=byte selected by index, most-significant byte first (index 0 = bits 31:24).
REQ-021 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0; a transfer occurs on an edge where both are 1.
REQ-022 On transfer with index<3: index increments, stay SEND; tx_valid SHALL remain 1 (back-to-back allowed).
REQ-023 On transfer with index=3: if address counter==last_addr go DONE, else counter increments modulo 2^ADDR_W and go READ.
REQ-024 last_addr<first_addr SHALL wrap through 2^ADDR_W-1 to 0; first_addr==last_addr SHALL dump exactly one word.
REQ-025 DONE (1 cycle): done=1, go IDLE; start in DONE ignored.
REQ-026 First tx_valid SHALL be high exactly 3 cycles after the edge sampling start; word-to-word gap after last byte handshake SHALL be 2 cycles of tx_valid=0.
REQ-027 busy SHALL be 1 in READ, WAIT, SEND, DONE; 0 in IDLE.
REQ-028 con_rd SHALL be 0 and con_addr SHALL hold last value outside READ.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE, tx_valid=0, con_rd=0, busy=0, done=0, con_addr=0, tx_data=0, byte index=0, abandoning any dump mid-word with no further transfers.
REQ-030 start sampled with rst=1 SHALL be ignored.

Structure
REQ-031 Shared package SHALL hold the state enumeration, BYTES_PER_WORD=4, and default ADDR_W/DATA_W.
REQ-032 Byte selection/shift SHALL be a sub-module dump_word_serializer (word register, 2-bit index, byte mux); FSM and address counter stay in datamem_dump_ctrl.

Verification
REQ-033 start, first=0x000, last=0x000, mem[0]=0xADE1B056, tx_ready=1 -> tx bytes AD,E1,B0,56 on 4 consecutive cycles, first tx_valid 3 cycles after start, done pulse once, busy falls.
REQ-034 first=0x010, last=0x012, tx_ready=1 -> con_addr sequence 0x010,0x011,0x012, 12 bytes, 2-cycle gaps between words.
REQ-035 first=0x3FE, last=0x001 -> addresses 0x3FE,0x3FF,0x000,0x001, 16 bytes.
REQ-036 tx_ready low for 5 cycles during byte 2 of 0xADE1B055 -> tx_data held at 0xB0 with tx_valid=1, then 0x55 follows; no byte lost or duplicated.
REQ-037 rst=1 during SEND byte 1 -> next cycle tx_valid=0, busy=0, no done pulse; later start restarts from new first_addr.
REQ-038 start pulsed again while busy -> ignored; single done pulse, byte count unchanged.
